// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among NREQ byte sources. A pending
//               request is selected, its byte captured and acknowledged, the
//               transmitter is started with a one-cycle pulse, and the frame is
//               tracked through tx_busy until it completes. If tx_busy never
//               rises within START_TO cycles the launch is abandoned and
//               start_err pulses.
//
// Parameters  : NREQ     - number of requesters (2..8)
//               DATA_W   - frame payload width
//               START_TO - cycles allowed for tx_busy to rise after launch (>=2)
//
// Ports       : clk       in   single clock, posedge
//               reset     in   asynchronous, active-low reset
//               req       in   level request per requester
//               req_data  in   requester i byte at [i*DATA_W +: DATA_W]
//               ack       out  one-cycle one-hot pulse, byte of requester captured
//               tx_busy   in   transmitter frame in progress
//               tx_start  out  one-cycle start pulse to transmitter
//               tx_data   out  byte presented to transmitter (held until next grant)
//               grant_id  out  index of last/current granted requester
//               arb_busy  out  high in every state except IDLE
//               start_err out  one-cycle pulse when the launch times out
//
// Build option: UART_ARB_FIXED_PRIO_EN - when defined, the lowest set req index
//               always wins and the round-robin pointer is held at 0. Default
//               (undefined) is round-robin starting from the pointer.
//
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATA_W   = 8,
    parameter int START_TO = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           ack,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      arb_busy,
    output logic                      start_err
);

    localparam int c_ID_W  = $clog2(NREQ);
    localparam int c_CNT_W = $clog2(START_TO);
    // The counter value at which the next silent edge is the START_TO-th
    // cycle after launch.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(START_TO - 2);
    localparam logic [NREQ-1:0]    c_ONE      = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [c_ID_W-1:0]  c_ID_LAST  = c_ID_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [NREQ-1:0]     r_ack;
    logic                r_txStart;
    logic [DATA_W-1:0]   r_txData;
    logic [c_ID_W-1:0]   r_grantId;
    logic                r_arbBusy;
    logic                r_startErr;
    logic [c_ID_W-1:0]   r_rrPtr;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_found;
    logic [c_ID_W-1:0]   w_winner;
    logic [c_ID_W-1:0]   w_idx;
    logic [DATA_W-1:0]   w_winData;
    logic [c_ID_W-1:0]   w_rrNext;

    // Winner search: walk the requesters starting at the search origin,
    // wrapping at NREQ; the first set bit encountered wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            w_idx = c_ID_W'(k);
`else
            w_idx = c_ID_W'((int'(r_rrPtr) + k) % NREQ);
`endif
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_winData = req_data[w_winner*DATA_W +: DATA_W];

    // Pointer moves just past the requester that was served (or dropped on
    // timeout), so that requester has lowest priority in the next search.
`ifdef UART_ARB_FIXED_PRIO_EN
    assign w_rrNext = '0;
`else
    assign w_rrNext = (r_grantId == c_ID_LAST) ? '0 : r_grantId + 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ack      <= '0;
            r_txStart  <= 1'b0;
            r_txData   <= '0;
            r_grantId  <= '0;
            r_arbBusy  <= 1'b0;
            r_startErr <= 1'b0;
            r_rrPtr    <= '0;
            r_cnt      <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            r_ack      <= '0;
            r_txStart  <= 1'b0;
            r_startErr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A busy transmitter blocks any grant.
                    if (w_found && !tx_busy) begin
                        r_ack     <= c_ONE << w_winner;
                        r_txStart <= 1'b1;
                        r_txData  <= w_winData;
                        r_grantId <= w_winner;
                        r_arbBusy <= 1'b1;
                        r_state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        // Launch abandoned: the byte was already acked and
                        // is dropped; the requester still loses its turn.
                        r_startErr <= 1'b1;
                        r_arbBusy  <= 1'b0;
                        r_rrPtr    <= w_rrNext;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_arbBusy <= 1'b0;
                        r_rrPtr   <= w_rrNext;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_arbBusy <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign tx_start  = r_txStart;
    assign tx_data   = r_txData;
    assign grant_id  = r_grantId;
    assign arb_busy  = r_arbBusy;
    assign start_err = r_startErr;

endmodule

`default_nettype wire
